// File: rtl/serializador_codigo_pkg.sv
// Shared definitions for the serial frame transmitter.
//   state_t      : transmitter FSM states
//   DATA_BITS    : payload width (one encoder nibble)
//   FRAME_BITS   : start + data + parity + stop
//   START_LEVEL / STOP_LEVEL : line levels of the framing bits
//   paridade()   : even-parity bit over a data nibble
package serializador_codigo_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int   DATA_BITS   = 4;
    localparam int   FRAME_BITS  = 7;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // XOR of the data bits, so data plus parity holds an even count of ones
    function automatic logic paridade(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/serializador_codigo_if.sv
// Handshake and line bundle between the encoder side and the transmitter.
//   dado_in    : encoded nibble (dado_in[0] is the encoder's s0)
//   valid_in   : dado_in valid this cycle
//   ready_out  : holding register empty
//   tx         : serial line, idles high
//   busy       : frame in progress or holding register full
//   frame_done : one-cycle pulse on the last cycle of a frame
// master = encoder/bench side, slave = transmitter.
interface serializador_codigo_if;
    import serializador_codigo_pkg::*;

    logic [DATA_BITS-1:0] dado_in;
    logic                 valid_in;
    logic                 ready_out;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (output dado_in, valid_in,
                    input  ready_out, tx, busy, frame_done);
    modport slave  (input  dado_in, valid_in,
                    output ready_out, tx, busy, frame_done);
endinterface

// File: rtl/serializador_codigo_contador_bit.sv
// Bit-period down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the bit period on the next edge
//   tick       : high on the last cycle of every bit period
// The counter reloads itself after each tick, so consecutive bit periods
// follow one another without any extra cycle.
module contador_bit #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);
    localparam logic [7:0] TOP = 8'(CLKS_PER_BIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load || count == 8'd0)
            count <= TOP;
        else
            count <= count - 8'd1;
    end

    assign tick = (count == 8'd0);
endmodule

// File: rtl/serializador_codigo.sv
// Serial transmitter for encoded nibbles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake + line bundle (slave modport)
// A one-entry holding register accepts the next word while the current one
// is being shifted out, so back-to-back frames leave no idle gap.
// Frame: start(0), d[0]..d[3], even parity, stop(1); CLKS_PER_BIT cycles each.
module serializador_codigo
    import serializador_codigo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serializador_codigo_if.slave  bus
);
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shifter;
    logic                 paridade_q;
    logic [1:0]           idx;
    logic                 tick;
    logic                 load_shift;

    // Keep the period counter parked while idle so START always gets a
    // full bit period.
    contador_bit #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state_q == IDLE) || load_shift),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        load_shift = 1'b0;
        case (state_q)
            IDLE:   if (hold_full) begin
                        state_d    = START;
                        load_shift = 1'b1;
                    end
            START:  if (tick) state_d = DATA;
            DATA:   if (tick && idx == 2'(DATA_BITS - 1)) state_d = PARITY;
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) begin
                        if (hold_full) begin
                            state_d    = START;
                            load_shift = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // load_shift only fires while hold_full=1, so accept and drain can
    // never coincide on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (load_shift) begin
            hold_full <= 1'b0;
        end else if (bus.valid_in && !hold_full) begin
            hold_q    <= bus.dado_in;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter    <= '0;
            paridade_q <= 1'b0;
            idx        <= '0;
        end else if (load_shift) begin
            shifter    <= hold_q;
            paridade_q <= paridade(hold_q);
            idx        <= '0;
        end else if (state_q == DATA && tick) begin
            shifter <= shifter >> 1;
            idx     <= idx + 2'd1;
        end
    end

    always_comb begin
        case (state_q)
            START:   bus.tx = START_LEVEL;
            DATA:    bus.tx = shifter[0];
            PARITY:  bus.tx = paridade_q;
            STOP:    bus.tx = STOP_LEVEL;
            default: bus.tx = 1'b1;
        endcase
    end

    assign bus.ready_out  = !hold_full;
    assign bus.busy       = (state_q != IDLE) || hold_full;
    assign bus.frame_done = (state_q == STOP) && tick;
endmodule
